// File: rtl/pipe_skid_if.sv
// Valid/ready handshake bundle for one pipeline register stage: upstream (in_*) and downstream (out_*) sides.
// master is the environment driving the stage; slave is the stage itself.
interface pipe_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline register with a one-entry skid buffer: full throughput, registered in_ready,
// synchronous flush, and a saturating count of back-pressured cycles.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  pipe_skid_if.slave       bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding equals the number of held beats, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept, emit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    accept      = bus.in_valid & in_ready_q;
    emit        = out_valid_q & bus.out_ready;
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end else if (accept) begin
          state_d     = TWO;
          skid_data_d = bus.in_data;
          skid_ctrl_d = bus.in_ctrl;
        end else if (emit) begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      end
      TWO: begin
        if (emit) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: begin
        state_d     = EMPTY;
        main_ctrl_d = '0;
      end
    endcase

    // Bubbles must never carry control, so the main control field is zeroed on any drain.
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
    stall_d     = (out_valid_q && !bus.out_ready) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  // Skid contents are only ever read in TWO, which reset cannot leave us in.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_ctrl_q <= skid_ctrl_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboarded tests for pipe_skid_reg: a 32-bit instance and a
// 1-bit instance with a 4-bit stall counter.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n0, flush0, reset_n1, flush1;
  logic [1:0]  occ0, occ1;
  logic [15:0] stall0;
  logic [3:0]  stall1;

  pipe_skid_if #(.DATA_W(32), .CTRL_W(8)) bus0 ();
  pipe_skid_if #(.DATA_W(1),  .CTRL_W(2)) bus1 ();

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) u0 (
    .clk(clk), .reset_n(reset_n0), .flush(flush0), .bus(bus0),
    .occupancy(occ0), .stall_cnt(stall0)
  );

  pipe_skid_reg #(.DATA_W(1), .CTRL_W(2), .CNT_W(4)) u1 (
    .clk(clk), .reset_n(reset_n1), .flush(flush1), .bus(bus1),
    .occupancy(occ1), .stall_cnt(stall1)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush0 = 1'b0; flush1 = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_ctrl = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_ctrl = '0; bus1.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n0 = 1'b0; reset_n1 = 1'b0;
    tick();
    reset_n0 = 1'b1; reset_n1 = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n0 = 1'b0; reset_n1 = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_data = 32'hDEAD_BEEF; bus0.in_ctrl = 8'hFF;
    bus1.in_valid = 1'b1; bus1.in_data = 1'b1; bus1.in_ctrl = 2'b11;
    tick(); tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b0100) begin
      errors++; $display("FAIL reset_u0_status: got %b expected 0100", {bus0.out_valid, bus0.in_ready, occ0});
    end
    checks++;
    if ({bus0.out_ctrl, bus0.out_data, stall0} !== 56'h0) begin
      errors++; $display("FAIL reset_u0_regs: ctrl %h data %h stall %0d expected all zero", bus0.out_ctrl, bus0.out_data, stall0);
    end
    checks++;
    if ({bus1.out_valid, bus1.in_ready, occ1, bus1.out_ctrl, bus1.out_data, stall1} !== 11'b01000000000) begin
      errors++; $display("FAIL reset_u1_all: got %b expected 01000000000",
                         {bus1.out_valid, bus1.in_ready, occ1, bus1.out_ctrl, bus1.out_data, stall1});
    end
    idle();
    reset_n0 = 1'b1; reset_n1 = 1'b1;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b0100) begin
      errors++; $display("FAIL reset_release_idle: got %b expected 0100", {bus0.out_valid, bus0.in_ready, occ0});
    end
  endtask

  task automatic test_streaming();
    do_reset();
    bus0.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus0.in_valid = 1'b1; bus0.in_data = 32'(i); bus0.in_ctrl = 8'(i + 16);
      tick();
      checks++;
      if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b1101 || bus0.out_data !== 32'(i) || bus0.out_ctrl !== 8'(i + 16)) begin
        errors++; $display("FAIL stream_beat%0d: valid %b ready %b occ %0d data %0d ctrl %0d expected 1 1 1 %0d %0d",
                           i, bus0.out_valid, bus0.in_ready, occ0, bus0.out_data, bus0.out_ctrl, i, i + 16);
      end
    end
    bus0.in_valid = 1'b0;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b0100 || bus0.out_ctrl !== 8'h0 || stall0 !== 16'd0) begin
      errors++; $display("FAIL stream_drain: valid %b ready %b occ %0d ctrl %h stall %0d expected 0 1 0 00 0",
                         bus0.out_valid, bus0.in_ready, occ0, bus0.out_ctrl, stall0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_data = 32'hA; bus0.in_ctrl = 8'h1A;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b1101 || bus0.out_data !== 32'hA) begin
      errors++; $display("FAIL bp_accept_a: status %b data %h expected 1101 a", {bus0.out_valid, bus0.in_ready, occ0}, bus0.out_data);
    end
    bus0.in_data = 32'hB; bus0.in_ctrl = 8'h1B;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b1010 || bus0.out_data !== 32'hA || bus0.out_ctrl !== 8'h1A) begin
      errors++; $display("FAIL bp_full: status %b data %h ctrl %h expected 1010 a 1a", {bus0.out_valid, bus0.in_ready, occ0}, bus0.out_data, bus0.out_ctrl);
    end
    bus0.in_data = 32'hC; bus0.in_ctrl = 8'h1C;
    tick(); tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b1010 || bus0.out_data !== 32'hA || stall0 !== 16'd3) begin
      errors++; $display("FAIL bp_hold: status %b data %h stall %0d expected 1010 a 3", {bus0.out_valid, bus0.in_ready, occ0}, bus0.out_data, stall0);
    end
    bus0.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b1101 || bus0.out_data !== 32'hB || bus0.out_ctrl !== 8'h1B) begin
      errors++; $display("FAIL bp_second_b: status %b data %h ctrl %h expected 1101 b 1b", {bus0.out_valid, bus0.in_ready, occ0}, bus0.out_data, bus0.out_ctrl);
    end
    tick();
    checks++;
    if ({bus0.out_valid, occ0} !== 3'b101 || bus0.out_data !== 32'hC || bus0.out_ctrl !== 8'h1C) begin
      errors++; $display("FAIL bp_third_c: status %b data %h ctrl %h expected 101 c 1c", {bus0.out_valid, occ0}, bus0.out_data, bus0.out_ctrl);
    end
    bus0.in_valid = 1'b0;
    tick();
    checks++;
    if ({bus0.out_valid, occ0} !== 3'b000 || stall0 !== 16'd3) begin
      errors++; $display("FAIL bp_end: valid %b occ %0d stall %0d expected 0 0 3", bus0.out_valid, occ0, stall0);
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_data = 32'h11; bus0.in_ctrl = 8'h21;
    tick();
    bus0.in_data = 32'h12; bus0.in_ctrl = 8'h22;
    tick();
    bus0.in_data = 32'hDD; bus0.in_ctrl = 8'h2D; flush0 = 1'b1;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b0100 || bus0.out_ctrl !== 8'h0 || stall0 !== 16'd2) begin
      errors++; $display("FAIL flush_two: valid %b ready %b occ %0d ctrl %h stall %0d expected 0 1 0 00 2",
                         bus0.out_valid, bus0.in_ready, occ0, bus0.out_ctrl, stall0);
    end
    flush0 = 1'b0; bus0.in_data = 32'hEE; bus0.in_ctrl = 8'h2E; bus0.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus0.out_valid, occ0} !== 3'b101 || bus0.out_data !== 32'hEE || bus0.out_ctrl !== 8'h2E) begin
      errors++; $display("FAIL flush_next_beat: status %b data %h ctrl %h expected 101 ee 2e", {bus0.out_valid, occ0}, bus0.out_data, bus0.out_ctrl);
    end
    bus0.in_valid = 1'b0;
    tick();
    checks++;
    if ({bus0.out_valid, occ0} !== 3'b000) begin
      errors++; $display("FAIL flush_no_residue: status %b expected 000", {bus0.out_valid, occ0});
    end
  endtask

  task automatic test_reset_in_two();
    do_reset();
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_data = 32'h31; bus0.in_ctrl = 8'h41;
    tick();
    bus0.in_data = 32'h32; bus0.in_ctrl = 8'h42;
    tick(); tick();
    reset_n0 = 1'b0; flush0 = 1'b1; bus0.in_data = 32'hFF; bus0.in_ctrl = 8'h4F;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, occ0} !== 4'b0100 || {bus0.out_ctrl, bus0.out_data, stall0} !== 56'h0) begin
      errors++; $display("FAIL rst_two: valid %b ready %b occ %0d ctrl %h data %h stall %0d expected 0 1 0 00 0 0",
                         bus0.out_valid, bus0.in_ready, occ0, bus0.out_ctrl, bus0.out_data, stall0);
    end
    reset_n0 = 1'b1; flush0 = 1'b0; bus0.in_data = 32'h55; bus0.in_ctrl = 8'h03; bus0.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus0.out_valid, occ0} !== 3'b101 || bus0.out_data !== 32'h55 || bus0.out_ctrl !== 8'h03) begin
      errors++; $display("FAIL rst_first_beat: status %b data %h ctrl %h expected 101 55 03", {bus0.out_valid, occ0}, bus0.out_data, bus0.out_ctrl);
    end
    bus0.in_valid = 1'b0;
    tick();
    checks++;
    if ({bus0.out_valid, occ0} !== 3'b000 || bus0.out_ctrl !== 8'h0) begin
      errors++; $display("FAIL rst_no_skid_leak: status %b ctrl %h expected 000 00", {bus0.out_valid, occ0}, bus0.out_ctrl);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_data = 1'b1; bus1.in_ctrl = 2'b10;
    tick();
    bus1.in_valid = 1'b0;
    repeat (20) tick();
    checks++;
    if (stall1 !== 4'd15 || bus1.out_valid !== 1'b1 || bus1.out_data !== 1'b1 || bus1.out_ctrl !== 2'b10) begin
      errors++; $display("FAIL sat_count: stall %0d valid %b data %b ctrl %b expected 15 1 1 10", stall1, bus1.out_valid, bus1.out_data, bus1.out_ctrl);
    end
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    checks++;
    if (stall1 !== 4'd15 || {bus1.out_valid, bus1.in_ready, occ1, bus1.out_ctrl} !== 6'b010000) begin
      errors++; $display("FAIL sat_after_flush: stall %0d status %b expected 15 010000", stall1, {bus1.out_valid, bus1.in_ready, occ1, bus1.out_ctrl});
    end
    tick();
    checks++;
    if (stall1 !== 4'd15) begin
      errors++; $display("FAIL sat_hold: stall %0d expected 15", stall1);
    end
  endtask

  task automatic test_random();
    logic [39:0] q0[$];
    logic [2:0]  q1[$];
    logic [39:0] ent0;
    logic [2:0]  ent1;
    logic        acc0, em0, acc1, em1, drain;
    do_reset();
    for (int cyc = 0; cyc < 420; cyc++) begin
      drain = (cyc >= 400);
      bus0.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
      bus0.in_data   = $urandom;
      bus0.in_ctrl   = 8'($urandom);
      bus0.out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      bus1.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
      bus1.in_data   = 1'($urandom);
      bus1.in_ctrl   = 2'($urandom);
      bus1.out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      acc0 = bus0.in_valid & bus0.in_ready; em0 = bus0.out_valid & bus0.out_ready;
      acc1 = bus1.in_valid & bus1.in_ready; em1 = bus1.out_valid & bus1.out_ready;
      ent0 = {bus0.in_ctrl, bus0.in_data};
      ent1 = {bus1.in_ctrl, bus1.in_data};
      if (em0) begin
        checks++;
        if (q0.size() == 0 || {bus0.out_ctrl, bus0.out_data} !== q0[0]) begin
          errors++; $display("FAIL rand_u0_order cyc %0d: got %h expected %h", cyc, {bus0.out_ctrl, bus0.out_data}, (q0.size() == 0) ? 40'h0 : q0[0]);
        end
      end
      if (em1) begin
        checks++;
        if (q1.size() == 0 || {bus1.out_ctrl, bus1.out_data} !== q1[0]) begin
          errors++; $display("FAIL rand_u1_order cyc %0d: got %b expected %b", cyc, {bus1.out_ctrl, bus1.out_data}, (q1.size() == 0) ? 3'b0 : q1[0]);
        end
      end
      checks++;
      if ((!bus0.out_valid && bus0.out_ctrl !== 8'h0) || (!bus1.out_valid && bus1.out_ctrl !== 2'b0)) begin
        errors++; $display("FAIL rand_bubble_ctrl cyc %0d: ctrl0 %h ctrl1 %b expected 0 on bubbles", cyc, bus0.out_ctrl, bus1.out_ctrl);
      end
      tick();
      if (em0 && q0.size() > 0) void'(q0.pop_front());
      if (acc0) q0.push_back(ent0);
      if (em1 && q1.size() > 0) void'(q1.pop_front());
      if (acc1) q1.push_back(ent1);
      checks++;
      if (int'(occ0) != q0.size() || int'(occ1) != q1.size()) begin
        errors++; $display("FAIL rand_occupancy cyc %0d: occ0 %0d occ1 %0d expected %0d %0d", cyc, occ0, occ1, q0.size(), q1.size());
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drain: left %0d %0d valid %b %b expected 0 0 0 0", q0.size(), q1.size(), bus0.out_valid, bus1.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_in_two();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
